// File: rtl/axi4_lite_register_master_if.sv
// AXI4-Lite configuration package and bus interface shared by masters and slaves.
package axi4_lite_pkg;
    typedef struct packed {
        int unsigned A;
        int unsigned N;
    } axi4_lite_cfg_t;
endpackage

interface axi4_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_register_master.sv
// Single-outstanding AXI4-Lite master driven by a command/response port.
// Optional watchdog abort: define AXI4_LITE_REGISTER_MASTER_TIMEOUT_EN.
module axi4_lite_register_master
    import axi4_lite_pkg::*;
#(
    parameter axi4_lite_cfg_t C = '{default: 0},
    parameter int TIMEOUT = 256,
    localparam int AW = (C.A == 32'd0) ? 32 : int'(C.A),
    localparam int NB = (C.N == 32'd0) ? 4 : int'(C.N),
    localparam int DW = NB * 8
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [NB-1:0] cmd_wstrb,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic [1:0]    rsp_resp,
    output logic          rsp_timeout,
    axi4_lite_if.master   axi4_m
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WR_B = 3'd2,
        RD_A = 3'd3,
        RD_R = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [NB-1:0] wstrb_q, wstrb_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_resp_q, rsp_resp_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          accept_s;
    logic          abort_s;

    assign accept_s = cmd_valid & cmd_ready_q;

`ifdef AXI4_LITE_REGISTER_MASTER_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic          done_s;

    // A completing handshake in the last watchdog cycle beats the abort.
    assign done_s  = ((state_q == WR_B) && axi4_m.bvalid) || ((state_q == RD_R) && axi4_m.rvalid);
    assign abort_s = (state_q != IDLE) && !done_s && (cnt_q == CNT_LAST);

    // Watchdog: cycles spent in the current transaction.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q <= '0;
        end else if (accept_s) begin
            cnt_q <= '0;
        end else if (state_q != IDLE) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= cnt_q;
        end
    end
`else
    logic unused_timeout_s;

    assign unused_timeout_s = ^TIMEOUT;
    assign abort_s          = 1'b0;
`endif

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        if (abort_s) begin
            state_d       = IDLE;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            cmd_ready_d   = 1'b1;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        addr_d      = cmd_addr;
                        wdata_d     = cmd_wdata;
                        wstrb_d     = cmd_wstrb;
                        cmd_ready_d = 1'b0;
                        if (cmd_wr) begin
                            state_d   = WR;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                        end else begin
                            state_d   = RD_A;
                            arvalid_d = 1'b1;
                        end
                    end else begin
                        cmd_ready_d = 1'b1;
                    end
                end
                WR: begin
                    // AW and W retire independently; B is awaited once both are gone.
                    awvalid_d = awvalid_q & ~axi4_m.awready;
                    wvalid_d  = wvalid_q & ~axi4_m.wready;
                    if (!awvalid_d && !wvalid_d) begin
                        state_d  = WR_B;
                        bready_d = 1'b1;
                    end else begin
                        state_d = WR;
                    end
                end
                WR_B: begin
                    if (axi4_m.bvalid) begin
                        state_d       = IDLE;
                        bready_d      = 1'b0;
                        cmd_ready_d   = 1'b1;
                        rsp_valid_d   = 1'b1;
                        rsp_resp_d    = axi4_m.bresp;
                        rsp_rdata_d   = '0;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        bready_d = 1'b1;
                    end
                end
                RD_A: begin
                    if (axi4_m.arready) begin
                        state_d   = RD_R;
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                    end else begin
                        arvalid_d = 1'b1;
                    end
                end
                RD_R: begin
                    if (axi4_m.rvalid) begin
                        state_d       = IDLE;
                        rready_d      = 1'b0;
                        cmd_ready_d   = 1'b1;
                        rsp_valid_d   = 1'b1;
                        rsp_resp_d    = axi4_m.rresp;
                        rsp_rdata_d   = axi4_m.rdata;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        rready_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    bready_d    = 1'b0;
                    arvalid_d   = 1'b0;
                    rready_d    = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_timeout    = rsp_timeout_q;

    assign axi4_m.awaddr  = addr_q;
    assign axi4_m.awprot  = 3'b000;
    assign axi4_m.awvalid = awvalid_q;
    assign axi4_m.wdata   = wdata_q;
    assign axi4_m.wstrb   = wstrb_q;
    assign axi4_m.wvalid  = wvalid_q;
    assign axi4_m.bready  = bready_q;
    assign axi4_m.araddr  = addr_q;
    assign axi4_m.arprot  = 3'b000;
    assign axi4_m.arvalid = arvalid_q;
    assign axi4_m.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_register_master.sv
// Bench for axi4_lite_register_master: vector table, hand-written corner cases and random traffic.
module tb_axi4_lite_register_master;
    import axi4_lite_pkg::*;

    localparam axi4_lite_cfg_t CFG = '{A: 32, N: 4};
    localparam int TO = 16;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        int          ar_dly;
        int          r_dly;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          exp_lat;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        bit          exp_to;
    } vec_t;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    axi4_lite_if #(.AW(32), .DW(32)) axi ();

    axi4_lite_register_master #(.C(CFG), .TIMEOUT(TO)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr      (cmd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .axi4_m      (axi)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Slave behaviour knobs and the command the slave expects to see on the bus.
    int          s_aw_dly, s_w_dly, s_b_dly, s_ar_dly, s_r_dly;
    logic [1:0]  s_resp;
    logic [31:0] s_rdata;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;

    int aw_vcnt = 0, w_vcnt = 0, ar_vcnt = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, rsp_cnt = 0;
    int aw_seen, w_seen, ar_seen, b_wait, r_wait;
    bit aw_done, w_done, b_pend, r_pend, p_aw, p_w, p_b, p_ar, p_r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    // Slave model: acts on the handshakes of the previous edge, then drives the next cycle.
    always @(negedge aclk) begin
        if (areset) begin
            {aw_done, w_done, b_pend, r_pend} = 4'b0000;
            {p_aw, p_w, p_b, p_ar, p_r} = 5'b00000;
            aw_seen = 0; w_seen = 0; ar_seen = 0; b_wait = 0; r_wait = 0;
            axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
            axi.bvalid = 1'b0; axi.rvalid = 1'b0;
            axi.bresp = 2'b00; axi.rresp = 2'b00; axi.rdata = 32'h0;
        end else begin
            if (rsp_valid) rsp_cnt++;
            if (p_aw) begin aw_done = 1'b1; aw_hs++; end
            if (p_w)  begin w_done = 1'b1; w_hs++; end
            if (p_b)  begin b_pend = 1'b0; b_hs++; end
            if (aw_done && w_done) begin
                b_pend = 1'b1; b_wait = 0; aw_done = 1'b0; w_done = 1'b0;
            end
            if (p_ar) begin r_pend = 1'b1; r_wait = 0; ar_hs++; end
            if (p_r)  begin r_pend = 1'b0; r_hs++; end
            if (axi.awvalid) begin
                aw_vcnt++;
                chk("awaddr", axi.awaddr, e_addr);
                chk("awprot", axi.awprot, 64'd0);
                axi.awready = (aw_seen >= s_aw_dly);
                aw_seen++;
            end else begin
                axi.awready = 1'b0; aw_seen = 0;
            end
            if (axi.wvalid) begin
                w_vcnt++;
                chk("wdata", axi.wdata, e_wdata);
                chk("wstrb", axi.wstrb, e_wstrb);
                axi.wready = (w_seen >= s_w_dly);
                w_seen++;
            end else begin
                axi.wready = 1'b0; w_seen = 0;
            end
            if (axi.arvalid) begin
                ar_vcnt++;
                chk("araddr", axi.araddr, e_addr);
                chk("arprot", axi.arprot, 64'd0);
                axi.arready = (ar_seen >= s_ar_dly);
                ar_seen++;
            end else begin
                axi.arready = 1'b0; ar_seen = 0;
            end
            axi.bvalid = b_pend && (b_wait >= s_b_dly);
            if (b_pend) b_wait++;
            axi.rvalid = r_pend && (r_wait >= s_r_dly);
            if (r_pend) r_wait++;
            axi.bresp = s_resp;
            axi.rresp = s_resp;
            axi.rdata = s_rdata;
            p_aw = axi.awvalid && axi.awready;
            p_w  = axi.wvalid && axi.wready;
            p_b  = axi.bvalid && axi.bready;
            p_ar = axi.arvalid && axi.arready;
            p_r  = axi.rvalid && axi.rready;
        end
    end

    // Reference model: latency and response derived from the slave delays.
    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        int   aw_w;
        aw_w        = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
        m.exp_lat   = v.wr ? (3 + aw_w + v.b_dly) : (3 + v.ar_dly + v.r_dly);
        m.exp_resp  = v.resp;
        m.exp_rdata = v.wr ? 32'h0 : v.rdata;
        m.exp_to    = 1'b0;
        return m;
    endfunction

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int aw, input int w, input int b,
                                input int ar, input int r, input logic [1:0] resp,
                                input logic [31:0] rdata, input int lat, input logic [1:0] eresp,
                                input logic [31:0] erdata, input bit eto);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.aw_dly = aw; v.w_dly = w; v.b_dly = b; v.ar_dly = ar; v.r_dly = r;
        v.resp = resp; v.rdata = rdata;
        v.exp_lat = lat; v.exp_resp = eresp; v.exp_rdata = erdata; v.exp_to = eto;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int k = 0;
        int aw0, w0, ar0, awh0, wh0, bh0, arh0, rh0, rc0;
        while (!cmd_ready && k < 100) begin tick(); k++; end
        chk("cmd_ready_wait", cmd_ready, 64'd1);
        e_addr = v.addr; e_wdata = v.wdata; e_wstrb = v.wstrb;
        s_aw_dly = v.aw_dly; s_w_dly = v.w_dly; s_b_dly = v.b_dly;
        s_ar_dly = v.ar_dly; s_r_dly = v.r_dly; s_resp = v.resp; s_rdata = v.rdata;
        aw0 = aw_vcnt; w0 = w_vcnt; ar0 = ar_vcnt;
        awh0 = aw_hs; wh0 = w_hs; bh0 = b_hs; arh0 = ar_hs; rh0 = r_hs; rc0 = rsp_cnt;
        cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_wstrb = ~v.wstrb;
        k = 1;
        chk("cmd_ready_after_accept", cmd_ready, 64'd0);
        chk("rsp_valid_width", rsp_valid, 64'd0);
        while (!rsp_valid && k < 300) begin tick(); k++; end
        chk("latency", 64'(k), 64'(v.exp_lat));
        chk("rsp_resp", rsp_resp, v.exp_resp);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_timeout", rsp_timeout, 64'(v.exp_to));
        chk("rsp_count", 64'(rsp_cnt - rc0), 64'd1);
        if (v.wr) begin
            chk("aw_valid_cycles", 64'(aw_vcnt - aw0), 64'(v.aw_dly + 1));
            chk("w_valid_cycles", 64'(w_vcnt - w0), 64'(v.w_dly + 1));
            chk("b_handshakes", 64'(b_hs - bh0), 64'd1);
            chk("aw_w_handshakes", 64'((aw_hs - awh0) + (w_hs - wh0)), 64'd2);
            chk("ar_unused_on_write", 64'(ar_vcnt - ar0), 64'd0);
        end else if (v.exp_to) begin
            chk("ar_valid_cycles_to", 64'(ar_vcnt - ar0), 64'(TO));
            chk("ar_handshakes_to", 64'(ar_hs - arh0), 64'd0);
        end else begin
            chk("ar_valid_cycles", 64'(ar_vcnt - ar0), 64'(v.ar_dly + 1));
            chk("r_handshakes", 64'((ar_hs - arh0) + (r_hs - rh0)), 64'd2);
            chk("aw_unused_on_read", 64'(aw_vcnt - aw0), 64'd0);
        end
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        int k;
        int rc0;
        areset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        s_aw_dly = 0; s_w_dly = 0; s_b_dly = 0; s_ar_dly = 0; s_r_dly = 0;
        s_resp = 2'b00; s_rdata = 32'h0; e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0;

        tbl.push_back(mk(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3, 2'b00, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h12345678, 3, 2'b00, 32'h12345678, 1'b0));
        tbl.push_back(mk(1'b1, 32'h10, 32'hA5A55A5A, 4'h3, 5, 0, 0, 0, 0, 2'b00, 32'h0, 8, 2'b00, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 32'hCAFEF00D, 3, 2'b11, 32'hCAFEF00D, 1'b0));
        tbl.push_back(mk(1'b1, 32'h24, 32'h01020304, 4'h5, 0, 0, 0, 0, 0, 2'b10, 32'h0, 3, 2'b10, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 32'h30, 32'h55AA00FF, 4'h8, 1, 3, 2, 0, 0, 2'b00, 32'h0, 8, 2'b00, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 0, 0, 0, 2, 3, 2'b01, 32'h89ABCDEF, 8, 2'b01, 32'h89ABCDEF, 1'b0));
`ifdef AXI4_LITE_REGISTER_MASTER_TIMEOUT_EN
        tbl.push_back(mk(1'b0, 32'h40, 32'h0, 4'h0, 0, 0, 0, 1000, 0, 2'b00, 32'h77777777, TO + 1, 2'b10, 32'h0, 1'b1));
`else
        tbl.push_back(mk(1'b0, 32'h40, 32'h0, 4'h0, 0, 0, 0, 40, 0, 2'b00, 32'h77777777, 43, 2'b00, 32'h77777777, 1'b0));
`endif
        tbl.push_back(mk(1'b0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0BADF00D, 3, 2'b00, 32'h0BADF00D, 1'b0));

        repeat (3) tick();
        areset = 1'b0;
        chk("reset_cmd_ready", cmd_ready, 64'd1);
        chk("reset_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 64'd0);
        chk("reset_readies", {axi.bready, axi.rready}, 64'd0);
        chk("reset_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 64'd0);

        for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i]);

        // Reset while waiting for B: abandoned, never answered.
        e_addr = 32'h50; e_wdata = 32'h13572468; e_wstrb = 4'hF;
        s_aw_dly = 0; s_w_dly = 0; s_b_dly = 1000; s_resp = 2'b00;
        cmd_wr = 1'b1; cmd_addr = e_addr; cmd_wdata = e_wdata; cmd_wstrb = e_wstrb;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        k = 0;
        while (!axi.bready && k < 20) begin tick(); k++; end
        chk("reached_wr_b", axi.bready, 64'd1);
        rc0 = rsp_cnt;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk("rst_mid_bready", axi.bready, 64'd0);
        chk("rst_mid_cmd_ready", cmd_ready, 64'd1);
        chk("rst_mid_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.rready}, 64'd0);
        chk("rst_mid_rsp", {rsp_valid, rsp_resp}, 64'd0);
        repeat (10) tick();
        chk("rst_mid_no_rsp", 64'(rsp_cnt - rc0), 64'd0);

        // Randomized back-to-back traffic against the model.
        for (int i = 0; i < 40; i++) begin
            rv.wr     = 1'($urandom_range(1, 0));
            rv.addr   = $urandom & 32'hFFFF_FFFC;
            rv.wdata  = $urandom;
            rv.wstrb  = 4'($urandom_range(15, 0));
            rv.aw_dly = $urandom_range(3, 0);
            rv.w_dly  = $urandom_range(3, 0);
            rv.b_dly  = $urandom_range(3, 0);
            rv.ar_dly = $urandom_range(3, 0);
            rv.r_dly  = $urandom_range(3, 0);
            rv.resp   = 2'($urandom_range(3, 0));
            rv.rdata  = $urandom;
            run_txn(model(rv));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
